// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall-vector layout, stage-register control codes, bubble instruction.
package pipe_pkg;

  localparam int STALL_PC_BIT  = 7;
  localparam int STALL_IFID_HI = 6;
  localparam int STALL_IFID_LO = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Both 2'b10 and 2'b11 mean FLUSH; decode_ctrl folds 2'b11 onto ST_FLUSH.
  typedef enum logic [1:0] {
    ST_ADV   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FLUSH = 2'b10
  } stall_ctrl_e;

  function automatic stall_ctrl_e decode_ctrl(input logic [1:0] code);
    if (code[1])      return ST_FLUSH;
    else if (code[0]) return ST_HOLD;
    else              return ST_ADV;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with advance / hold / flush control.
// A flush overwrites only the bits selected by BUBBLE_MASK.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int           W           = 32,
  parameter logic [W-1:0] RESET_VAL   = '0,
  parameter logic [W-1:0] BUBBLE_VAL  = '0,
  parameter logic [W-1:0] BUBBLE_MASK = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  stall_ctrl_e   ctrl,
  input  logic [W-1:0]  d,
  output logic [W-1:0]  q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else begin
      case (ctrl)
        ST_ADV:  q <= d;
        ST_HOLD: q <= q;
        default: q <= (q & ~BUBBLE_MASK) | (BUBBLE_VAL & BUBBLE_MASK);
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: next-PC selection, PC/valid registers, IF/ID register and fetch counter.
// IMEM is synchronous, so pc names the word arriving on imem_rdata this cycle.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      stall,
  input  logic            EX_MEM_brsel,
  input  logic [XLEN-1:0] EX_MEM_brtgt,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic [31:0]     fetch_count
);

  localparam int              IFID_W      = 2 * XLEN + 33;
  localparam logic [XLEN-1:0] RESET_PC4   = RESET_PC + XLEN'(4);
  localparam logic [IFID_W-1:0] IFID_RESET  = {RESET_PC, RESET_PC4, NOP_INSTR, 1'b0};
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {{(2*XLEN){1'b0}}, NOP_INSTR, 1'b0};
  localparam logic [IFID_W-1:0] IFID_MASK   = {{(2*XLEN){1'b0}}, {33{1'b1}}};

  logic [XLEN-1:0]   pc;
  logic              pc_valid;
  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   pc_plus4;
  stall_ctrl_e       ifid_ctrl;
  logic [IFID_W-1:0] ifid_d;
  logic [IFID_W-1:0] ifid_q;

  logic unused_inputs;
  assign unused_inputs = ^{stall[4:0], EX_MEM_brtgt[1:0]};

  assign pc_plus4 = pc + XLEN'(4);

  // Redirect beats everything; before the first genuine IMEM word the address is re-issued.
  always_comb begin
    pc_next = pc_plus4;
    if (EX_MEM_brsel)
      pc_next = {EX_MEM_brtgt[XLEN-1:2], 2'b00};
    else if (!pc_valid || stall[STALL_PC_BIT])
      pc_next = pc;
  end

  assign imem_addr = rst ? RESET_PC : pc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
    end else begin
      pc       <= pc_next;
      pc_valid <= 1'b1;
    end
  end

  always_comb begin
    ifid_ctrl = decode_ctrl(stall[STALL_IFID_HI:STALL_IFID_LO]);
    if (EX_MEM_brsel)
      ifid_ctrl = ST_FLUSH;
    else if (ifid_ctrl == ST_ADV && !pc_valid)
      ifid_ctrl = ST_FLUSH;
  end

  assign ifid_d = {pc, pc_plus4, imem_rdata, 1'b1};

  pipe_reg #(
    .W          (IFID_W),
    .RESET_VAL  (IFID_RESET),
    .BUBBLE_VAL (IFID_BUBBLE),
    .BUBBLE_MASK(IFID_MASK)
  ) u_if_id (
    .clk (clk),
    .rst (rst),
    .ctrl(ifid_ctrl),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  assign {if_id_pc, if_id_pc4, if_id_instr, if_id_valid} = ifid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fetch_count <= '0;
    else if (ifid_ctrl == ST_ADV)
      fetch_count <= fetch_count + 32'd1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect traffic against a reference model.
module tb_fetch_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  stall;
  logic        brsel;
  logic [31:0] brtgt;

  logic [31:0] a_imem_addr, a_rdata, a_if_id_pc, a_if_id_pc4, a_if_id_instr, a_fetch_count;
  logic        a_if_id_valid;
  logic [31:0] b_imem_addr, b_rdata, b_if_id_pc, b_if_id_pc4, b_if_id_instr, b_fetch_count;
  logic        b_if_id_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .EX_MEM_brsel(brsel), .EX_MEM_brtgt(brtgt),
    .imem_addr(a_imem_addr), .imem_rdata(a_rdata),
    .if_id_pc(a_if_id_pc), .if_id_pc4(a_if_id_pc4), .if_id_instr(a_if_id_instr),
    .if_id_valid(a_if_id_valid), .fetch_count(a_fetch_count)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .EX_MEM_brsel(brsel), .EX_MEM_brtgt(brtgt),
    .imem_addr(b_imem_addr), .imem_rdata(b_rdata),
    .if_id_pc(b_if_id_pc), .if_id_pc4(b_if_id_pc4), .if_id_instr(b_if_id_instr),
    .if_id_valid(b_if_id_valid), .fetch_count(b_fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  // synchronous IMEM: word for the address presented this cycle appears after the edge
  always @(posedge clk) begin
    a_rdata <= mem_word(a_imem_addr);
    b_rdata <= mem_word(b_imem_addr);
  end

  // Reference model of instance A: fetch address, IF/ID contents, load count.
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt, cnt_bias;
  logic        m_pcv, m_valid;

  function automatic logic [31:0] model_next();
    if (brsel) return brtgt & ~32'h3;
    if (!m_pcv || stall[7]) return m_pc;
    return m_pc + 32'd4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_pcv <= 1'b0; m_ipc <= 32'h0; m_instr <= NOP_INSTR;
      m_valid <= 1'b0; m_cnt <= 32'h0;
    end else begin
      if (brsel || stall[6] || (stall[6:5] == 2'b00 && !m_pcv)) begin
        m_instr <= NOP_INSTR; m_valid <= 1'b0;
      end else if (stall[6:5] == 2'b00) begin
        m_ipc <= m_pc; m_instr <= mem_word(m_pc); m_valid <= 1'b1; m_cnt <= m_cnt + 32'd1;
      end
      m_pc  <= model_next();
      m_pcv <= 1'b1;
    end
  end

  task automatic test_reset();
    rst = 1'b1; stall = 8'h0; brsel = 1'b0; brtgt = 32'h0; cnt_bias = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_if_id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", a_if_id_pc, 32'h0); end
    n_cmp++; if (a_if_id_pc4 !== 32'h4) begin n_bad++; $display("FAIL reset_pc4: got %h want %h", a_if_id_pc4, 32'h4); end
    n_cmp++; if (a_if_id_instr !== NOP_INSTR) begin n_bad++; $display("FAIL reset_instr: got %h want %h", a_if_id_instr, NOP_INSTR); end
    n_cmp++; if (a_if_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", a_if_id_valid); end
    n_cmp++; if (a_fetch_count !== 32'h0) begin n_bad++; $display("FAIL reset_count: got %h want 0", a_fetch_count); end
    n_cmp++; if (a_imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", a_imem_addr); end
    n_cmp++; if (b_if_id_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL reset_b_pc: got %h want fffffffc", b_if_id_pc); end
    n_cmp++; if (b_if_id_pc4 !== 32'h0) begin n_bad++; $display("FAIL reset_b_pc4: got %h want 0", b_if_id_pc4); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    @(posedge clk); #1;
    n_cmp++; if (a_if_id_valid !== 1'b0) begin n_bad++; $display("FAIL first_bubble_valid: got %b want 0", a_if_id_valid); end
    n_cmp++; if (a_if_id_instr !== NOP_INSTR) begin n_bad++; $display("FAIL first_bubble_instr: got %h want %h", a_if_id_instr, NOP_INSTR); end
    n_cmp++; if (a_imem_addr !== 32'h4) begin n_bad++; $display("FAIL first_addr: got %h want 4", a_imem_addr); end
    @(posedge clk); #1;
    n_cmp++; if (a_if_id_pc !== 32'h0) begin n_bad++; $display("FAIL first_pc: got %h want 0", a_if_id_pc); end
    n_cmp++; if (a_if_id_instr !== 32'h0050_0093) begin n_bad++; $display("FAIL first_instr: got %h want 00500093", a_if_id_instr); end
    n_cmp++; if (a_if_id_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid: got %b want 1", a_if_id_valid); end
    n_cmp++; if (a_fetch_count !== 32'h1) begin n_bad++; $display("FAIL first_count: got %h want 1", a_fetch_count); end
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (a_if_id_pc !== 32'(4*i)) begin n_bad++; $display("FAIL run_pc: got %h want %h", a_if_id_pc, 32'(4*i)); end
      n_cmp++; if (a_if_id_pc4 !== 32'(4*i+4)) begin n_bad++; $display("FAIL run_pc4: got %h want %h", a_if_id_pc4, 32'(4*i+4)); end
      n_cmp++; if (a_if_id_instr !== mem_word(32'(4*i))) begin n_bad++; $display("FAIL run_instr: got %h want %h", a_if_id_instr, mem_word(32'(4*i))); end
      n_cmp++; if (a_fetch_count !== 32'(i+1)) begin n_bad++; $display("FAIL run_count: got %h want %h", a_fetch_count, 32'(i+1)); end
      n_cmp++; if (a_imem_addr !== 32'(4*i+8)) begin n_bad++; $display("FAIL run_addr: got %h want %h", a_imem_addr, 32'(4*i+8)); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] h_pc, h_cnt;
    @(negedge clk);
    h_pc = a_if_id_pc; h_cnt = a_fetch_count;
    stall = 8'b1_01_11_00_0;
    #1;
    n_cmp++; if (a_imem_addr !== h_pc + 32'd4) begin n_bad++; $display("FAIL stall_addr: got %h want %h", a_imem_addr, h_pc + 32'd4); end
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++; if (a_if_id_pc !== h_pc) begin n_bad++; $display("FAIL stall_pc: got %h want %h", a_if_id_pc, h_pc); end
      n_cmp++; if (a_if_id_instr !== mem_word(h_pc)) begin n_bad++; $display("FAIL stall_instr: got %h want %h", a_if_id_instr, mem_word(h_pc)); end
      n_cmp++; if (a_fetch_count !== h_cnt) begin n_bad++; $display("FAIL stall_count: got %h want %h", a_fetch_count, h_cnt); end
      n_cmp++; if (a_imem_addr !== h_pc + 32'd4) begin n_bad++; $display("FAIL stall_hold_addr: got %h want %h", a_imem_addr, h_pc + 32'd4); end
    end
    @(negedge clk) stall = 8'h0;
    #1;
    n_cmp++; if (a_imem_addr !== h_pc + 32'd8) begin n_bad++; $display("FAIL unstall_addr: got %h want %h", a_imem_addr, h_pc + 32'd8); end
    @(posedge clk); #1;
    n_cmp++; if (a_if_id_pc !== h_pc + 32'd4) begin n_bad++; $display("FAIL unstall_pc: got %h want %h", a_if_id_pc, h_pc + 32'd4); end
    n_cmp++; if (a_if_id_instr !== mem_word(h_pc + 32'd4)) begin n_bad++; $display("FAIL unstall_instr: got %h want %h", a_if_id_instr, mem_word(h_pc + 32'd4)); end
    n_cmp++; if (a_fetch_count !== h_cnt + 32'd1) begin n_bad++; $display("FAIL unstall_count: got %h want %h", a_fetch_count, h_cnt + 32'd1); end
  endtask

  task automatic test_branch();
    logic [31:0] h_pc;
    @(negedge clk);
    h_pc = a_if_id_pc;
    stall = 8'b0_11_11_11_0; brsel = 1'b1; brtgt = 32'h0000_0102;
    #1;
    n_cmp++; if (a_imem_addr !== 32'h100) begin n_bad++; $display("FAIL br_addr: got %h want 100", a_imem_addr); end
    @(posedge clk); #1;
    n_cmp++; if (a_if_id_instr !== NOP_INSTR) begin n_bad++; $display("FAIL br_flush_instr: got %h want %h", a_if_id_instr, NOP_INSTR); end
    n_cmp++; if (a_if_id_valid !== 1'b0) begin n_bad++; $display("FAIL br_flush_valid: got %b want 0", a_if_id_valid); end
    n_cmp++; if (a_if_id_pc !== h_pc) begin n_bad++; $display("FAIL br_flush_pc: got %h want %h", a_if_id_pc, h_pc); end
    @(negedge clk) begin brsel = 1'b0; stall = 8'h0; end
    #1;
    n_cmp++; if (a_imem_addr !== 32'h104) begin n_bad++; $display("FAIL br_next_addr: got %h want 104", a_imem_addr); end
    @(posedge clk); #1;
    n_cmp++; if (a_if_id_pc !== 32'h100) begin n_bad++; $display("FAIL br_tgt_pc: got %h want 100", a_if_id_pc); end
    n_cmp++; if (a_if_id_pc4 !== 32'h104) begin n_bad++; $display("FAIL br_tgt_pc4: got %h want 104", a_if_id_pc4); end
    n_cmp++; if (a_if_id_instr !== mem_word(32'h100)) begin n_bad++; $display("FAIL br_tgt_instr: got %h want %h", a_if_id_instr, mem_word(32'h100)); end
    n_cmp++; if (a_if_id_valid !== 1'b1) begin n_bad++; $display("FAIL br_tgt_valid: got %b want 1", a_if_id_valid); end
  endtask

  task automatic test_branch_over_stall();
    logic [31:0] t;
    t = $urandom & 32'h00FF_FFFC;
    @(negedge clk);
    stall = 8'b1_01_00000; brsel = 1'b1; brtgt = t | ($urandom & 32'h3);
    #1;
    n_cmp++; if (a_imem_addr !== t) begin n_bad++; $display("FAIL bos_addr: got %h want %h", a_imem_addr, t); end
    @(posedge clk); #1;
    n_cmp++; if (a_if_id_valid !== 1'b0) begin n_bad++; $display("FAIL bos_valid: got %b want 0", a_if_id_valid); end
    n_cmp++; if (a_if_id_instr !== NOP_INSTR) begin n_bad++; $display("FAIL bos_instr: got %h want %h", a_if_id_instr, NOP_INSTR); end
    @(negedge clk) brsel = 1'b0;
    #1;
    n_cmp++; if (a_imem_addr !== t) begin n_bad++; $display("FAIL bos_hold_addr: got %h want %h", a_imem_addr, t); end
    @(negedge clk) stall = 8'h0;
    @(posedge clk); #1;
    n_cmp++; if (a_if_id_pc !== t) begin n_bad++; $display("FAIL bos_tgt_pc: got %h want %h", a_if_id_pc, t); end
    n_cmp++; if (a_if_id_instr !== mem_word(t)) begin n_bad++; $display("FAIL bos_tgt_instr: got %h want %h", a_if_id_instr, mem_word(t)); end
  endtask

  task automatic test_random(input int cycles);
    logic [31:0] e;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      stall = 8'($urandom);
      if ($urandom_range(0, 3) != 0) stall[7] = 1'b0;
      if ($urandom_range(0, 2) != 0) stall[6:5] = 2'b00;
      brsel = ($urandom_range(0, 9) == 0);
      brtgt = $urandom;
      #1;
      e = model_next();
      n_cmp++; if (a_imem_addr !== e) begin n_bad++; $display("FAIL rnd_addr: cycle %0d got %h want %h", c, a_imem_addr, e); end
      @(posedge clk); #1;
      n_cmp++; if (a_if_id_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid: cycle %0d got %b want %b", c, a_if_id_valid, m_valid); end
      n_cmp++; if (a_if_id_instr !== m_instr) begin n_bad++; $display("FAIL rnd_instr: cycle %0d got %h want %h", c, a_if_id_instr, m_instr); end
      n_cmp++; if (a_if_id_pc !== m_ipc) begin n_bad++; $display("FAIL rnd_pc: cycle %0d got %h want %h", c, a_if_id_pc, m_ipc); end
      n_cmp++; if (a_if_id_pc4 !== m_ipc + 32'd4) begin n_bad++; $display("FAIL rnd_pc4: cycle %0d got %h want %h", c, a_if_id_pc4, m_ipc + 32'd4); end
      n_cmp++; if (a_fetch_count !== m_cnt + cnt_bias) begin n_bad++; $display("FAIL rnd_count: cycle %0d got %h want %h", c, a_fetch_count, m_cnt + cnt_bias); end
    end
    @(negedge clk) begin stall = 8'h0; brsel = 1'b0; end
  endtask

  task automatic test_count_wrap();
    @(posedge clk);
    @(negedge clk);
    stall = 8'h0; brsel = 1'b0;
    force dut_a.fetch_count = 32'hFFFF_FFFF;
    cnt_bias = 32'hFFFF_FFFF - m_cnt;
    #1 release dut_a.fetch_count;
    #1;
    n_cmp++; if (a_fetch_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cnt_preset: got %h want ffffffff", a_fetch_count); end
    @(posedge clk); #1;
    n_cmp++; if (a_fetch_count !== 32'h0) begin n_bad++; $display("FAIL cnt_wrap: got %h want 0", a_fetch_count); end
  endtask

  task automatic test_pc_wrap();
    @(negedge clk);
    stall = 8'h0; brsel = 1'b0; rst = 1'b1; cnt_bias = 32'h0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (b_if_id_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_bubble: got %b want 0", b_if_id_valid); end
    n_cmp++; if (b_imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", b_imem_addr); end
    @(posedge clk); #1;
    n_cmp++; if (b_if_id_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc_last: got %h want fffffffc", b_if_id_pc); end
    n_cmp++; if (b_if_id_pc4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got %h want 0", b_if_id_pc4); end
    n_cmp++; if (b_if_id_instr !== mem_word(32'hFFFF_FFFC)) begin n_bad++; $display("FAIL wrap_instr: got %h want %h", b_if_id_instr, mem_word(32'hFFFF_FFFC)); end
    @(posedge clk); #1;
    n_cmp++; if (b_if_id_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc_zero: got %h want 0", b_if_id_pc); end
    n_cmp++; if (b_if_id_instr !== 32'h0050_0093) begin n_bad++; $display("FAIL wrap_instr0: got %h want 00500093", b_if_id_instr); end
    n_cmp++; if (b_fetch_count !== 32'h2) begin n_bad++; $display("FAIL wrap_count: got %h want 2", b_fetch_count); end
  endtask

  task automatic test_reset_mid_stall();
    repeat (3) @(posedge clk);
    @(negedge clk);
    stall = 8'b1_01_00000; brsel = 1'b1; brtgt = 32'h0000_0200;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (a_if_id_pc !== 32'h0) begin n_bad++; $display("FAIL mid_rst_pc: got %h want 0", a_if_id_pc); end
    n_cmp++; if (a_if_id_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", a_if_id_valid); end
    n_cmp++; if (a_if_id_instr !== NOP_INSTR) begin n_bad++; $display("FAIL mid_rst_instr: got %h want %h", a_if_id_instr, NOP_INSTR); end
    n_cmp++; if (a_fetch_count !== 32'h0) begin n_bad++; $display("FAIL mid_rst_count: got %h want 0", a_fetch_count); end
    n_cmp++; if (a_imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_addr: got %h want 0", a_imem_addr); end
    @(negedge clk) begin rst = 1'b0; stall = 8'h0; brsel = 1'b0; end
    @(posedge clk); #1;
    n_cmp++; if (a_if_id_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_bubble: got %b want 0", a_if_id_valid); end
    @(posedge clk); #1;
    n_cmp++; if (a_if_id_pc !== 32'h0) begin n_bad++; $display("FAIL mid_rst_refetch: got %h want 0", a_if_id_pc); end
    n_cmp++; if (a_if_id_valid !== 1'b1) begin n_bad++; $display("FAIL mid_rst_refetch_valid: got %b want 1", a_if_id_valid); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_free_run();
    test_stall();
    test_branch();
    test_branch_over_stall();
    test_random(400);
    test_count_wrap();
    test_random(100);
    test_pc_wrap();
    test_reset_mid_stall();
    test_random(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
